// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
//
// Shared constants for the multiplexed seven-segment scan controller.
//   BCD_BLANK   : nibble that the downstream decoder renders as all segments off
//   STATE_BLANK : scan phase with every anode released
//   STATE_DRIVE : scan phase with one anode pulled low
//   ANODES_OFF  : all-ones anode pattern (active-low), sliced to NUM_DIGITS
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_BLANK = 4'hF;

  // Single-bit phase encoding keeps the state register legacy-friendly.
  localparam logic [0:0] STATE_BLANK = 1'b0;
  localparam logic [0:0] STATE_DRIVE = 1'b1;

  // Wide enough for any practical digit count; users slice the low bits.
  localparam logic [31:0] ANODES_OFF = 32'hFFFF_FFFF;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl_if
//
// Bundles the control and display signals of the scan controller.
//   enable     : scanning enable (low = display dark)
//   load       : one-cycle strobe staging digits_in
//   digits_in  : 4*NUM_DIGITS BCD nibbles, digit 0 in the low nibble
//   bcd_out    : nibble toward the shared decoder
//   digit_en   : active-low anode enables, bit i drives digit i
//   pending    : staged data waits for the next frame boundary
//   frame_done : one-cycle pulse after each frame boundary
// Modports: master drives the controls, slave is the scan controller.
// ---------------------------------------------------------------------------
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output enable,
    output load,
    output digits_in,
    input  bcd_out,
    input  digit_en,
    input  pending,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  load,
    input  digits_in,
    output bcd_out,
    output digit_en,
    output pending,
    output frame_done
  );

endinterface

// File: rtl/scan_slot_timer.sv
// ---------------------------------------------------------------------------
// scan_slot_timer
//
// Decides when the current scan phase ends. A slot is BLANK_CYCLES of blank
// followed by REFRESH_DIV-BLANK_CYCLES of drive.
//   cnt_i          : slot counter, restarted at 0 at every phase change
//   phase_i        : STATE_BLANK or STATE_DRIVE
//   end_of_phase_o : high on the last cycle of the current phase
// ---------------------------------------------------------------------------
module scan_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = $clog2(REFRESH_DIV)
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [0:0]       phase_i,
  output logic             end_of_phase_o
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

  // The counter restarts on every phase change, so each phase only needs to
  // recognise its own final count.
  always_comb begin
    end_of_phase_o = 1'b0;
    if (phase_i == STATE_BLANK) begin
      end_of_phase_o = (cnt_i == BLANK_LAST);
    end else begin
      end_of_phase_o = (cnt_i == DRIVE_LAST);
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits that
// share one BCD-to-7-segment decoder. New values are staged by a load strobe
// and copied into the displayed shadow buffer only at frame boundaries, so a
// frame never mixes old and new digits.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : seven_seg_scan_ctrl_if.slave (enable, load, digits_in inputs;
//           bcd_out, digit_en, pending, frame_done registered outputs)
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_seg_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BUF_W = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF    = ANODES_OFF[NUM_DIGITS-1:0];
  localparam logic [BUF_W-1:0]      BLANK_BUF  = {NUM_DIGITS{BCD_BLANK}};

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BUF_W-1:0]      staging_q, staging_d;
  logic [BUF_W-1:0]      shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [3:0]            bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

  logic                  end_of_phase;
  logic                  boundary;
  logic [3:0]            shadow_nibble;

  scan_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .cnt_i          (cnt_q),
    .phase_i        (state_q),
    .end_of_phase_o (end_of_phase)
  );

  // Scan sequencing. Enable low parks the scanner at digit 0 in BLANK and is
  // treated as a frame boundary on every edge, so staged data still commits
  // while the display is dark.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!bus.enable) begin
      state_d  = STATE_BLANK;
      cnt_d    = '0;
      idx_d    = '0;
      boundary = 1'b1;
    end else if (end_of_phase) begin
      cnt_d = '0;
      if (state_q == STATE_BLANK) begin
        state_d = STATE_DRIVE;
      end else begin
        state_d = STATE_BLANK;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          boundary = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Buffer handling. The commit uses the staging value from before this edge,
  // so a load landing on the boundary edge is kept pending for the next frame
  // instead of being displayed early.
  always_comb begin
    staging_d    = staging_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = boundary;
    if (boundary && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end
    if (bus.load) begin
      staging_d = bus.digits_in;
      pending_d = 1'b1;
    end
  end

  // Pick the nibble for the upcoming digit from the next-state shadow so the
  // registered outputs line up with the state register without extra latency.
  always_comb begin
    shadow_nibble = BCD_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        shadow_nibble = shadow_d[4*i +: 4];
      end
    end
  end

  // Output decode from next state: blank everything in BLANK, otherwise pull
  // exactly one anode low and present its nibble.
  always_comb begin
    bcd_out_d  = BCD_BLANK;
    digit_en_d = ALL_OFF;
    if (state_d == STATE_DRIVE) begin
      bcd_out_d = shadow_nibble;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          digit_en_d[i] = 1'b0;
        end
      end
    end
  end

  // All state and output registers share the asynchronous reset so the
  // display goes dark the moment reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= STATE_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      staging_q    <= BLANK_BUF;
      shadow_q     <= BLANK_BUF;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      bcd_out_q    <= BCD_BLANK;
      digit_en_q   <= ALL_OFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      bcd_out_q    <= bcd_out_d;
      digit_en_q   <= digit_en_d;
    end
  end

  assign bus.bcd_out    = bcd_out_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Cycle k is the value seen after the k-th rising edge since
// reset release (k=0 is the reset state). A slot is 8 cycles: k%8 in {0,1} is
// blank, 2..7 drives digit (k/8)%4; a frame is 32 cycles.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;
  import seven_seg_pkg::*;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  localparam int STIM_LOAD   = 0;
  localparam int STIM_EN_LOW = 1;
  localparam int STIM_EN_HI  = 2;

  typedef struct {
    int         phase;
    int         cyc;
    logic [3:0] bcd;
    logic [3:0] en;
    logic       pend;
    logic       fd;
    string      name;
  } chk_t;

  typedef struct {
    int          phase;
    int          cyc;
    int          kind;
    logic [15:0] data;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  chk_t  checks[$];
  stim_t stims[$];

  int numChecks = 0;
  int numFails  = 0;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void addChk(int ph, int c, logic [3:0] b, logic [3:0] e,
                                 logic p, logic f, string n);
    checks.push_back('{ph, c, b, e, p, f, n});
  endfunction

  function automatic void addStim(int ph, int c, int kind, logic [15:0] d);
    stims.push_back('{ph, c, kind, d});
  endfunction

  task automatic checkOutput(string name, logic [3:0] bcd, logic [3:0] en,
                             logic pend, logic fd);
    logic [9:0] act;
    logic [9:0] exp;
    act = {bus.bcd_out, bus.digit_en, bus.pending, bus.frame_done};
    exp = {bcd, en, pend, fd};
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got bcd=%h en=%b pend=%b fd=%b, want bcd=%h en=%b pend=%b fd=%b",
               name, bus.bcd_out, bus.digit_en, bus.pending, bus.frame_done,
               bcd, en, pend, fd);
    end
  endtask

  task automatic applyStimulus(int ph, int k);
    foreach (stims[i]) begin
      if (stims[i].phase == ph && stims[i].cyc == k) begin
        case (stims[i].kind)
          STIM_LOAD: begin
            bus.load      = 1'b1;
            bus.digits_in = stims[i].data;
          end
          STIM_EN_LOW: bus.enable = 1'b0;
          default:     bus.enable = 1'b1;
        endcase
      end
    end
  endtask

  // Called at the falling edge right after reset release (k=0).
  task automatic runPhase(int ph, int lastCyc);
    for (int k = 0; k <= lastCyc; k++) begin
      if (k > 0) @(negedge clk);
      bus.load = 1'b0;
      foreach (checks[i]) begin
        if (checks[i].phase == ph && checks[i].cyc == k) begin
          checkOutput(checks[i].name, checks[i].bcd, checks[i].en,
                      checks[i].pend, checks[i].fd);
        end
      end
      applyStimulus(ph, k);
    end
  endtask

  initial begin
    // Phase 1: scan, loads, boundary load, enable drop.
    addChk(1,   0, 4'hF, 4'b1111, 0, 0, "reset_state");
    addChk(1,   1, 4'hF, 4'b1111, 0, 0, "first_blank");
    addChk(1,   2, 4'hF, 4'b1110, 0, 0, "first_drive_d0");
    addStim(1,  5, STIM_LOAD, 16'h1234);
    addChk(1,   6, 4'hF, 4'b1110, 1, 0, "pending_after_load");
    addChk(1,   7, 4'hF, 4'b1110, 1, 0, "d0_last_drive");
    addChk(1,   8, 4'hF, 4'b1111, 1, 0, "blank_before_d1");
    addChk(1,  10, 4'hF, 4'b1101, 1, 0, "drive_d1_old");
    addChk(1,  18, 4'hF, 4'b1011, 1, 0, "drive_d2_old");
    addChk(1,  26, 4'hF, 4'b0111, 1, 0, "drive_d3_old");
    addChk(1,  31, 4'hF, 4'b0111, 1, 0, "frame0_last");
    addChk(1,  32, 4'hF, 4'b1111, 0, 1, "boundary1_commit");
    addChk(1,  33, 4'hF, 4'b1111, 0, 0, "frame_done_one_cycle");
    addChk(1,  34, 4'h4, 4'b1110, 0, 0, "f1_d0_shows_4");
    addChk(1,  42, 4'h3, 4'b1101, 0, 0, "f1_d1_shows_3");
    addChk(1,  50, 4'h2, 4'b1011, 0, 0, "f1_d2_shows_2");
    addChk(1,  58, 4'h1, 4'b0111, 0, 0, "f1_d3_shows_1");
    addChk(1,  64, 4'hF, 4'b1111, 0, 1, "boundary2_no_pending");
    addStim(1, 70, STIM_LOAD, 16'h1111);
    addChk(1,  71, 4'h4, 4'b1110, 1, 0, "first_of_two_loads");
    addStim(1, 80, STIM_LOAD, 16'h9876);
    addChk(1,  90, 4'h1, 4'b0111, 1, 0, "f2_d3_unchanged");
    addChk(1,  96, 4'hF, 4'b1111, 0, 1, "boundary3_commit");
    addChk(1,  98, 4'h6, 4'b1110, 0, 0, "last_load_wins_d0");
    addChk(1, 106, 4'h7, 4'b1101, 0, 0, "last_load_wins_d1");
    addChk(1, 114, 4'h8, 4'b1011, 0, 0, "last_load_wins_d2");
    addChk(1, 122, 4'h9, 4'b0111, 0, 0, "last_load_wins_d3");
    addStim(1, 130, STIM_LOAD, 16'h1234);
    addChk(1, 131, 4'h6, 4'b1110, 1, 0, "pending_1234_again");
    addStim(1, 159, STIM_LOAD, 16'h5555);
    addChk(1, 159, 4'h9, 4'b0111, 1, 0, "before_boundary_load");
    addChk(1, 160, 4'hF, 4'b1111, 1, 1, "boundary_load_keeps_pending");
    addChk(1, 162, 4'h4, 4'b1110, 1, 0, "bl_frame_d0_old_stage");
    addChk(1, 170, 4'h3, 4'b1101, 1, 0, "bl_frame_d1_old_stage");
    addChk(1, 178, 4'h2, 4'b1011, 1, 0, "bl_frame_d2_old_stage");
    addChk(1, 186, 4'h1, 4'b0111, 1, 0, "bl_frame_d3_old_stage");
    addChk(1, 192, 4'hF, 4'b1111, 0, 1, "boundary_commit_5555");
    addChk(1, 194, 4'h5, 4'b1110, 0, 0, "f6_d0_shows_5");
    addChk(1, 218, 4'h5, 4'b0111, 0, 0, "f6_d3_shows_5");
    addStim(1, 226, STIM_LOAD, 16'h0042);
    addStim(1, 235, STIM_EN_LOW, 16'h0);
    addChk(1, 235, 4'h5, 4'b1101, 1, 0, "d1_before_disable");
    addChk(1, 236, 4'hF, 4'b1111, 0, 1, "disable_blanks_commits");
    addStim(1, 237, STIM_EN_HI, 16'h0);
    addChk(1, 237, 4'hF, 4'b1111, 0, 1, "disable_boundary_each_edge");
    addChk(1, 238, 4'hF, 4'b1111, 0, 0, "reenable_blank");
    addChk(1, 239, 4'h2, 4'b1110, 0, 0, "reenable_d0_shows_2");
    addChk(1, 247, 4'h4, 4'b1101, 0, 0, "reenable_d1_shows_4");
    addChk(1, 255, 4'h0, 4'b1011, 0, 0, "reenable_d2_shows_0");
    addChk(1, 269, 4'hF, 4'b1111, 0, 1, "reenable_frame_boundary");
    addStim(1, 275, STIM_LOAD, 16'h7777);
    addChk(1, 275, 4'h2, 4'b1110, 0, 0, "before_7777_load");
    addChk(1, 289, 4'h0, 4'b1011, 1, 0, "mid_d2_before_reset");
    // Phase 2: after the mid-slot asynchronous reset.
    addChk(2,   0, 4'hF, 4'b1111, 0, 0, "post_reset_state");
    addChk(2,   2, 4'hF, 4'b1110, 0, 0, "post_reset_d0_blank");
    addChk(2,  10, 4'hF, 4'b1101, 0, 0, "post_reset_d1_blank");
    addChk(2,  18, 4'hF, 4'b1011, 0, 0, "post_reset_d2_blank");
    addChk(2,  26, 4'hF, 4'b0111, 0, 0, "post_reset_d3_blank");
    addChk(2,  32, 4'hF, 4'b1111, 0, 1, "post_reset_boundary");

    bus.enable    = 1'b1;
    bus.load      = 1'b0;
    bus.digits_in = '0;

    #1 reset = 1'b1;
    #1 checkOutput("async_reset_initial", 4'hF, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    runPhase(1, 289);

    // Mid-DRIVE of digit 2 with 7777 pending: reset must act without a clock.
    #2 reset = 1'b1;
    #1 checkOutput("async_reset_mid_drive", 4'hF, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    runPhase(2, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
